// File: rtl/dphy_rx_pkg.sv
// dphy_rx_pkg: shared types and helpers for the D-PHY HS receive byte path.
package dphy_rx_pkg;

    // Byte aligner state machine encoding.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEARCH   = 2'd1,
        ST_LOCKED   = 2'd2,
        ST_WAIT_LOW = 2'd3
    } align_state_t;

    // HS leader-sequence byte, bit 0 = earliest received bit.
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hB8;

    // Index of the lowest set bit of an 8-bit vector (0 when the vector is empty).
    function automatic logic [2:0] lowest_set_idx(input logic [7:0] vec);
        logic [2:0] idx;
        if (vec[0])      idx = 3'd0;
        else if (vec[1]) idx = 3'd1;
        else if (vec[2]) idx = 3'd2;
        else if (vec[3]) idx = 3'd3;
        else if (vec[4]) idx = 3'd4;
        else if (vec[5]) idx = 3'd5;
        else if (vec[6]) idx = 3'd6;
        else if (vec[7]) idx = 3'd7;
        else             idx = 3'd0;
        return idx;
    endfunction

endpackage

// File: rtl/dphy_sync_detect.sv
// dphy_sync_detect: looks for the sync byte at all 8 bit offsets of a 16-bit
// window and reports the lowest matching offset.
// Build macro DPHY_SYNC_ERR_TOLERANT_EN: when no exact match exists, a slice one
// bit away from the sync byte is accepted and flagged on o_soft.
module dphy_sync_detect
    import dphy_rx_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic [15:0] i_win,
    output logic        o_hit,
    output logic [2:0]  o_offset
`ifdef DPHY_SYNC_ERR_TOLERANT_EN
    ,
    output logic        o_soft
`endif
);

    logic [7:0] w_exact;
`ifdef DPHY_SYNC_ERR_TOLERANT_EN
    logic [7:0] w_near;
`endif

    for (genvar g = 0; g < 8; g++) begin : g_slice
        assign w_exact[g] = (i_win[g+7:g] == SYNC_BYTE);
`ifdef DPHY_SYNC_ERR_TOLERANT_EN
        logic [7:0] w_diff;
        assign w_diff    = i_win[g+7:g] ^ SYNC_BYTE;
        // Exactly one differing bit: non-zero and a power of two.
        assign w_near[g] = (w_diff != 8'd0) && ((w_diff & (w_diff - 8'd1)) == 8'd0);
`endif
    end

    // Priority select: exact matches always beat 1-bit matches, lowest offset wins.
    always_comb begin
        o_hit    = 1'b0;
        o_offset = 3'd0;
`ifdef DPHY_SYNC_ERR_TOLERANT_EN
        o_soft   = 1'b0;
`endif
        if (|w_exact) begin
            o_hit    = 1'b1;
            o_offset = lowest_set_idx(w_exact);
        end
`ifdef DPHY_SYNC_ERR_TOLERANT_EN
        else if (|w_near) begin
            o_hit    = 1'b1;
            o_offset = lowest_set_idx(w_near);
            o_soft   = 1'b1;
        end
`endif
        else begin
            o_hit    = 1'b0;
            o_offset = 3'd0;
        end
    end

endmodule

// File: rtl/dphy_hs_byte_align.sv
// dphy_hs_byte_align: per-lane HS sync search and byte alignment in the byte
// clock domain. Locks the bit offset of the sync byte and then streams aligned
// payload bytes. Build macro DPHY_SYNC_ERR_TOLERANT_EN adds 1-bit-error sync
// acceptance and the sync_soft_err_o port.
module dphy_hs_byte_align
    import dphy_rx_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT,
    parameter int unsigned SYNC_TIMEOUT = 32'd32
) (
    input  logic       byte_clk_i,
    input  logic       rst_i,
    input  logic       hs_active_i,
    input  logic [7:0] byte_data_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       sync_found_o,
    output logic       sync_err_o,
    output logic       locked_o
`ifdef DPHY_SYNC_ERR_TOLERANT_EN
    ,
    output logic       sync_soft_err_o
`endif
);

    // Last search cycle index; the timeout fires when the timer sits here unmatched.
    localparam logic [7:0] TIMER_LAST = 8'(SYNC_TIMEOUT - 32'd1);

    align_state_t r_state;
    logic [7:0]   r_prev;
    logic [7:0]   r_timer;
    logic [2:0]   r_offset;
    logic [7:0]   r_byte;
    logic         r_valid;
    logic         r_found;
    logic         r_err;
    logic         r_locked;

    logic [15:0]  w_win;
    logic [7:0]   w_aligned;
    logic         w_hit;
    logic [2:0]   w_offset;
`ifdef DPHY_SYNC_ERR_TOLERANT_EN
    logic         w_soft;
    logic         r_soft;
`endif

    // Previous word sits in the low half: its bits were received first.
    assign w_win     = {byte_data_i, r_prev};
    assign w_aligned = w_win[{1'b0, r_offset} +: 8];

    dphy_sync_detect #(
        .SYNC_BYTE (SYNC_BYTE)
    ) u_sync_detect (
        .i_win    (w_win),
        .o_hit    (w_hit),
        .o_offset (w_offset)
`ifdef DPHY_SYNC_ERR_TOLERANT_EN
        ,
        .o_soft   (w_soft)
`endif
    );

    // Previous-word register feeding the 16-bit search/alignment window.
    always_ff @(posedge byte_clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_prev <= 8'd0;
        end else begin
            r_prev <= byte_data_i;
        end
    end

    // Alignment FSM with search timer and registered status/data outputs.
    always_ff @(posedge byte_clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state  <= ST_IDLE;
            r_timer  <= 8'd0;
            r_offset <= 3'd0;
            r_byte   <= 8'd0;
            r_valid  <= 1'b0;
            r_found  <= 1'b0;
            r_err    <= 1'b0;
            r_locked <= 1'b0;
`ifdef DPHY_SYNC_ERR_TOLERANT_EN
            r_soft   <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            r_found <= 1'b0;
            r_err   <= 1'b0;
`ifdef DPHY_SYNC_ERR_TOLERANT_EN
            r_soft  <= 1'b0;
`endif
            if (!hs_active_i) begin
                // Leaving HS mode aborts everything; a match this cycle is ignored.
                r_state  <= ST_IDLE;
                r_locked <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_SEARCH;
                        r_timer <= 8'd0;
                    end
                    ST_SEARCH: begin
                        if (w_hit) begin
                            // A match wins over a simultaneous timeout.
                            r_offset <= w_offset;
                            r_found  <= 1'b1;
                            r_locked <= 1'b1;
                            r_state  <= ST_LOCKED;
`ifdef DPHY_SYNC_ERR_TOLERANT_EN
                            r_soft   <= w_soft;
`endif
                        end else if (r_timer == TIMER_LAST) begin
                            r_err   <= 1'b1;
                            r_state <= ST_WAIT_LOW;
                        end else begin
                            r_timer <= r_timer + 8'd1;
                        end
                    end
                    ST_LOCKED: begin
                        r_byte  <= w_aligned;
                        r_valid <= 1'b1;
                    end
                    ST_WAIT_LOW: begin
                        // No re-search inside the same burst.
                        r_state <= ST_WAIT_LOW;
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign byte_o       = r_byte;
    assign byte_valid_o = r_valid;
    assign sync_found_o = r_found;
    assign sync_err_o   = r_err;
    assign locked_o     = r_locked;
`ifdef DPHY_SYNC_ERR_TOLERANT_EN
    assign sync_soft_err_o = r_soft;
`endif

endmodule

// File: tb/tb_dphy_hs_byte_align.sv
// tb_dphy_hs_byte_align: directed scenarios plus randomized traffic checked
// against a bit-stream reference model. Honours DPHY_SYNC_ERR_TOLERANT_EN.
module tb_dphy_hs_byte_align;

    localparam logic [7:0] SYNC = 8'hB8;
    localparam int         TMO  = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       hs;
    logic [7:0] din;
    logic [7:0] byte_o;
    logic       byte_valid_o;
    logic       sync_found_o;
    logic       sync_err_o;
    logic       locked_o;
    logic       soft_o;
`ifndef DPHY_SYNC_ERR_TOLERANT_EN
    assign soft_o = 1'b0;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    dphy_hs_byte_align #(
        .SYNC_BYTE    (8'hB8),
        .SYNC_TIMEOUT (32)
    ) dut (
        .byte_clk_i   (clk),
        .rst_i        (rst_n),
        .hs_active_i  (hs),
        .byte_data_i  (din),
        .byte_o       (byte_o),
        .byte_valid_o (byte_valid_o),
        .sync_found_o (sync_found_o),
        .sync_err_o   (sync_err_o),
        .locked_o     (locked_o)
`ifdef DPHY_SYNC_ERR_TOLERANT_EN
        ,
        .sync_soft_err_o (soft_o)
`endif
    );

    // ---------------- reference model (received bit stream) ----------------
    bit         m_bits[$];
    int         m_mode;      // 0 idle, 1 searching, 2 locked, 3 waiting for hs low
    int         m_searched;  // search cycles spent without a match
    int         m_ptr;       // stream position of the next payload byte
    logic [7:0] m_byte;
    logic       m_valid, m_found, m_err, m_locked, m_soft;

    function automatic logic [7:0] stream_byte(input int pos);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_bits[pos + i];
        return v;
    endfunction

    task automatic model_reset();
        m_bits.delete();
        for (int i = 0; i < 8; i++) m_bits.push_back(1'b0);
        m_mode = 0; m_searched = 0; m_ptr = 0;
        m_byte = 8'h00; m_valid = 1'b0; m_found = 1'b0;
        m_err = 1'b0; m_locked = 1'b0; m_soft = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] d, input logic a);
        int n, k_hit, k_near;
        for (int i = 0; i < 8; i++) m_bits.push_back(d[i]);
        n = m_bits.size();
        m_found = 1'b0; m_err = 1'b0; m_soft = 1'b0; m_valid = 1'b0;
        if (!a) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            m_mode = 1; m_searched = 0;
        end else if (m_mode == 1) begin
            k_hit = -1; k_near = -1;
            for (int k = 7; k >= 0; k--) begin
                if (stream_byte(n - 16 + k) == SYNC) k_hit = k;
                if ($countones(stream_byte(n - 16 + k) ^ SYNC) == 1) k_near = k;
            end
`ifndef DPHY_SYNC_ERR_TOLERANT_EN
            k_near = -1;
`endif
            if (k_hit >= 0 || k_near >= 0) begin
                m_ptr   = n - 16 + ((k_hit >= 0) ? k_hit : k_near) + 8;
                m_found = 1'b1;
                m_soft  = (k_hit < 0);
                m_mode  = 2;
            end else begin
                m_searched++;
                if (m_searched == TMO) begin
                    m_err  = 1'b1;
                    m_mode = 3;
                end
            end
        end else if (m_mode == 2) begin
            m_byte  = stream_byte(m_ptr);
            m_ptr   = m_ptr + 8;
            m_valid = 1'b1;
        end
        m_locked = (m_mode == 2);
    endtask

    // Drive one word at a negedge, advance the model, land on the next negedge.
    task automatic tick(input logic [7:0] d, input logic a);
        din = d;
        hs  = a;
        model_step(d, a);
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; hs = 1'b0; din = 8'h00;
        model_reset();
        #3;
        tests_run++;
        if ({byte_o, byte_valid_o, sync_found_o, sync_err_o, locked_o, soft_o} !== 13'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h/%b%b%b%b%b expected all zero", byte_o, byte_valid_o, sync_found_o, sync_err_o, locked_o, soft_o);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_aligned();
        tick(8'h00, 1'b0); tick(8'h00, 1'b1); tick(8'hB8, 1'b1);
        tests_run++;
        if ({sync_found_o, byte_valid_o} !== 2'b00) begin
            tests_failed++;
            $display("FAIL aligned_early: got found/valid=%b%b expected 00", sync_found_o, byte_valid_o);
        end
        tick(8'h12, 1'b1);
        tests_run++;
        if ({sync_found_o, locked_o, byte_valid_o, soft_o} !== 4'b1100) begin
            tests_failed++;
            $display("FAIL aligned_found: got found/locked/valid/soft=%b%b%b%b expected 1100", sync_found_o, locked_o, byte_valid_o, soft_o);
        end
        tick(8'h34, 1'b1);
        tests_run++;
        if ({byte_valid_o, byte_o, sync_found_o} !== {1'b1, 8'h12, 1'b0}) begin
            tests_failed++;
            $display("FAIL aligned_byte0: got valid=%b byte=%h found=%b expected 1 12 0", byte_valid_o, byte_o, sync_found_o);
        end
        tick(8'h56, 1'b1);
        tests_run++;
        if ({byte_valid_o, byte_o} !== {1'b1, 8'h34}) begin
            tests_failed++;
            $display("FAIL aligned_byte1: got valid=%b byte=%h expected 1 34", byte_valid_o, byte_o);
        end
    endtask

    task automatic test_offset3();
        tick(8'h00, 1'b0); tick(8'h00, 1'b1); tick(8'hC0, 1'b1); tick(8'h2D, 1'b1);
        tests_run++;
        if ({sync_found_o, locked_o, byte_valid_o} !== 3'b110) begin
            tests_failed++;
            $display("FAIL offset3_found: got found/locked/valid=%b%b%b expected 110", sync_found_o, locked_o, byte_valid_o);
        end
        tick(8'h05, 1'b1);
        tests_run++;
        if ({byte_valid_o, byte_o} !== {1'b1, 8'hA5}) begin
            tests_failed++;
            $display("FAIL offset3_byte: got valid=%b byte=%h expected 1 a5", byte_valid_o, byte_o);
        end
    endtask

    task automatic test_timeout();
        int err_cnt, err_at, valid_seen, found_seen;
        err_cnt = 0; err_at = -1; valid_seen = 0; found_seen = 0;
        tick(8'h00, 1'b0);
        for (int i = 1; i <= 40; i++) begin
            tick(8'h00, 1'b1);
            if (sync_err_o === 1'b1) begin err_cnt++; err_at = i; end
            if (byte_valid_o === 1'b1) valid_seen++;
        end
        tests_run++;
        if (err_cnt != 1 || err_at != 33) begin
            tests_failed++;
            $display("FAIL timeout_pulse: got %0d pulses last at tick %0d expected 1 at tick 33", err_cnt, err_at);
        end
        tests_run++;
        if (valid_seen != 0) begin
            tests_failed++;
            $display("FAIL timeout_valid: got %0d valid cycles expected 0", valid_seen);
        end
        // A sync inside the same burst must not be picked up.
        tick(8'hB8, 1'b1); tick(8'h12, 1'b1);
        if (sync_found_o === 1'b1) found_seen++;
        tick(8'h34, 1'b1);
        if (sync_found_o === 1'b1 || locked_o === 1'b1) found_seen++;
        tests_run++;
        if (found_seen != 0) begin
            tests_failed++;
            $display("FAIL timeout_no_research: got %0d lock indications expected 0", found_seen);
        end
        tick(8'h00, 1'b0); tick(8'h00, 1'b1); tick(8'hB8, 1'b1); tick(8'h12, 1'b1);
        tests_run++;
        if ({sync_found_o, locked_o} !== 2'b11) begin
            tests_failed++;
            $display("FAIL timeout_relock: got found/locked=%b%b expected 11", sync_found_o, locked_o);
        end
    endtask

    task automatic test_abort();
        tick(8'h00, 1'b0); tick(8'h00, 1'b1); tick(8'hB8, 1'b1); tick(8'h12, 1'b1);
        tick(8'h34, 1'b1);
        tick(8'h77, 1'b0);
        tests_run++;
        if ({byte_valid_o, locked_o, byte_o} !== {1'b0, 1'b0, 8'h12}) begin
            tests_failed++;
            $display("FAIL abort_drop: got valid=%b locked=%b byte=%h expected 0 0 12", byte_valid_o, locked_o, byte_o);
        end
        tick(8'hB8, 1'b0); tick(8'h12, 1'b0);
        tests_run++;
        if ({sync_found_o, locked_o} !== 2'b00) begin
            tests_failed++;
            $display("FAIL abort_match_ignored: got found/locked=%b%b expected 00", sync_found_o, locked_o);
        end
        tick(8'h00, 1'b1); tick(8'h00, 1'b1); tick(8'h17, 1'b1);
        tests_run++;
        if ({sync_found_o, locked_o} !== 2'b11) begin
            tests_failed++;
            $display("FAIL abort_relock5: got found/locked=%b%b expected 11", sync_found_o, locked_o);
        end
        tick(8'hAB, 1'b1);
        tests_run++;
        if ({byte_valid_o, byte_o} !== {1'b1, 8'h58}) begin
            tests_failed++;
            $display("FAIL abort_off5_byte: got valid=%b byte=%h expected 1 58", byte_valid_o, byte_o);
        end
    endtask

    task automatic test_reset_mid_lock();
        tick(8'hCD, 1'b1);
        tests_run++;
        if ({byte_valid_o, byte_o} !== {1'b1, 8'h6D}) begin
            tests_failed++;
            $display("FAIL midlock_stream: got valid=%b byte=%h expected 1 6d", byte_valid_o, byte_o);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({byte_o, byte_valid_o, sync_found_o, sync_err_o, locked_o, soft_o} !== 13'd0) begin
            tests_failed++;
            $display("FAIL midlock_async_reset: got %h/%b%b%b%b%b expected all zero", byte_o, byte_valid_o, sync_found_o, sync_err_o, locked_o, soft_o);
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick(8'h00, 1'b1); tick(8'hB8, 1'b1); tick(8'h12, 1'b1);
        tests_run++;
        if ({sync_found_o, locked_o} !== 2'b11) begin
            tests_failed++;
            $display("FAIL midlock_research: got found/locked=%b%b expected 11", sync_found_o, locked_o);
        end
    endtask

    task automatic test_tolerant();
        int err_cnt, found_cnt;
        err_cnt = 0; found_cnt = 0;
        tick(8'h00, 1'b0); tick(8'h00, 1'b1); tick(8'hB9, 1'b1); tick(8'h00, 1'b1);
`ifdef DPHY_SYNC_ERR_TOLERANT_EN
        tests_run++;
        if ({sync_found_o, soft_o, locked_o} !== 3'b111) begin
            tests_failed++;
            $display("FAIL tolerant_soft: got found/soft/locked=%b%b%b expected 111", sync_found_o, soft_o, locked_o);
        end
`else
        if (sync_found_o === 1'b1) found_cnt++;
        for (int i = 0; i < 40; i++) begin
            tick(8'h00, 1'b1);
            if (sync_err_o === 1'b1) err_cnt++;
            if (sync_found_o === 1'b1) found_cnt++;
        end
        tests_run++;
        if (err_cnt != 1 || found_cnt != 0) begin
            tests_failed++;
            $display("FAIL tolerant_off_timeout: got %0d err pulses %0d locks expected 1 0", err_cnt, found_cnt);
        end
`endif
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       a;
        a = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 31) == 0) a = ~a;
            if ($urandom_range(0, 15) == 0) d = SYNC;
            else                            d = 8'($urandom);
            tick(d, a);
            tests_run++;
            if ({byte_o, byte_valid_o, sync_found_o, sync_err_o, locked_o, soft_o} !== {m_byte, m_valid, m_found, m_err, m_locked, m_soft}) begin
                tests_failed++;
                $display("FAIL random_cycle%0d: got byte=%h v/f/e/l/s=%b%b%b%b%b expected byte=%h v/f/e/l/s=%b%b%b%b%b", c, byte_o, byte_valid_o, sync_found_o, sync_err_o, locked_o, soft_o, m_byte, m_valid, m_found, m_err, m_locked, m_soft);
            end
            tests_run++;
            if ((sync_found_o & sync_err_o) !== 1'b0) begin
                tests_failed++;
                $display("FAIL random_found_err_excl%0d: got both=%b expected 0", c, sync_found_o & sync_err_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_offset3();
        test_timeout();
        test_abort();
        test_reset_mid_lock();
        test_tolerant();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dphy_hs_byte_align.md
Name: dphy_hs_byte_align

Overview:
Sits directly downstream of the per-lane HS deserializer, in the byte clock domain. Consumes the raw 8-bit words, which have arbitrary bit alignment. Searches the stream for the HS sync byte at any of 8 bit offsets, locks the offset, and emits byte-aligned payload with a valid strobe to the lane merger / packet parser. Provides sync-found and sync-timeout indications to the lane control FSM.

Parameters:
SYNC_BYTE, 8'hB8, HS leader-sequence byte, in the bit order of byte_data_i.
SYNC_TIMEOUT, 32, byte clocks allowed in SEARCH before the timeout error; range 2..255.

Ports:
byte_clk_i  input  1  byte clock; all logic on rising edge
rst_i  input  1  asynchronous, active-low reset
hs_active_i  input  1  lane in HS receive mode; a rising edge starts the search, low aborts it
byte_data_i  input  8  raw deserialized word; bit 0 = earliest received bit
byte_o  output  8  aligned byte; bit 0 = earliest bit
byte_valid_o  output  1  byte_o holds payload this cycle
sync_found_o  output  1  one-cycle pulse when the sync byte is locked
sync_err_o  output  1  one-cycle pulse on search timeout
locked_o  output  1  level; high in the LOCKED state

Behaviour:
- Reset (rst_i low, async): state IDLE; prev_q=0, offset_q=0, timer=0. All outputs 0.
- Window: win = {byte_data_i, prev_q} (16 bits). prev_q <= byte_data_i every cycle, in all states.
- Match: match[k] = (win[k+7:k] == SYNC_BYTE) for k = 0..7.
- FSM states: IDLE, SEARCH, LOCKED, WAIT_LOW.
- IDLE -> SEARCH when hs_active_i=1. The timer clears on this transition.
- SEARCH:
  - If any match[k]: offset_q <= lowest k with a match, sync_found_o pulses next cycle, go to LOCKED.
  - Otherwise the timer increments.
  - When the timer reaches SYNC_TIMEOUT-1 with no match: sync_err_o pulses next cycle, go to WAIT_LOW.
- LOCKED: each cycle, byte_o <= win[offset_q+7 : offset_q] and byte_valid_o <= 1.
  - The first valid byte is the one immediately following the sync byte; the sync byte is never output.
  - Latency: the aligned byte appears on byte_o one cycle after the input word that completes it.
- WAIT_LOW: outputs idle until hs_active_i=0, then go to IDLE. This prevents a re-search inside the same burst.
- hs_active_i=0 in any state -> IDLE. byte_valid_o and locked_o are 0 from the next cycle. Any match in that same cycle is ignored.
- Simultaneous match and timeout in the same cycle: the match wins.
- Several offsets matching at once: the lowest k wins.
- byte_o holds its last value when byte_valid_o=0.
- sync_found_o and sync_err_o are never asserted together.

Optional Feature:
Macro DPHY_SYNC_ERR_TOLERANT_EN.
- Defined: in SEARCH, a window slice with Hamming distance exactly 1 from SYNC_BYTE is also accepted, but only when no exact match exists at any offset.
  - Offset selection is lowest-k among the 1-bit matches.
  - Extra output port sync_soft_err_o (1 bit) pulses together with sync_found_o.
- Undefined: exact match only, and the port is absent.

Decomposition:
- Package dphy_rx_pkg holds:
  - the state enum typedef (IDLE/SEARCH/LOCKED/WAIT_LOW);
  - the SYNC_BYTE default constant;
  - a function returning the lowest set index of an 8-bit match vector.
- One sub-module, dphy_sync_detect: combinational match vector plus priority offset encode, and Hamming-1 detection when the macro is defined. The FSM, timer and output registers stay in the top module.

Test Plan:
- Aligned sync: hs_active_i=1; inputs 0x00, 0xB8, 0x12, 0x34 -> match at k=0 when prev_q=0xB8. sync_found_o pulses, then byte_o=0x12, 0x34 with byte_valid_o=1. 0xB8 is never valid.
- Offset 3: inputs 0x00, 0xC0, 0x2D, 0x05 -> lock offset 3 while cur=0x2D, prev=0xC0. First valid byte_o=0xA5, one cycle after 0x05 is presented.
- Timeout: hs_active_i=1 with constant 0x00 for 40 cycles -> single sync_err_o pulse after 32 cycles, byte_valid_o stays 0. Remains idle until hs_active_i toggles low then high.
- Abort: locked and streaming, then drop hs_active_i -> byte_valid_o=0 and locked_o=0 next cycle. Re-raise with a new sync at offset 5 -> relocks at 5.
- Reset mid-LOCKED: assert rst_i=0 asynchronously -> all outputs 0 immediately. After release with hs_active_i=1, the FSM is in SEARCH.
- Tolerant (macro defined): sync 0xB9 at offset 0 -> sync_found_o and sync_soft_err_o pulse together. Without the macro: timeout instead.
